// File: rtl/sync_fifo_pkg.sv
// Shared width helpers and default threshold constants for the threshold FIFO.
package sync_fifo_pkg;

    // Default almost-empty threshold and distance of almost-full from the top.
    localparam int AE_THRESH_DEF = 2;
    localparam int AF_MARGIN_DEF = 2;

    // Pointer width: enough bits to index DEPTH entries.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: one extra bit so the value DEPTH is representable.
    function automatic int cnt_w(input int depth);
        return addr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W register array with one write port and a registered read port.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [addr_w(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       re,
    input  logic [addr_w(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register: loads only on an accepted read, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_thresh
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - AF_MARGIN_DEF,
    parameter int AE_THRESH = AE_THRESH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      winc,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      rinc,
    output logic [DATA_W-1:0]         rdata,
    input  logic                      flush,
    input  logic                      err_clr,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    // Reject illegal configurations while elaborating.
    if (DATA_W < 1) begin : g_bad_data_w
        $fatal(1, "sync_fifo_thresh: DATA_W must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo_thresh: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo_thresh: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_thresh: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              wr_ok;
    logic              rd_ok;
    logic              ovf_set;
    logic              udf_set;

    // Status flags come straight from the registered occupancy.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A flush cycle swallows both requests, including their error side effects.
    assign wr_ok   = winc && !full  && !flush;
    assign rd_ok   = rinc && !empty && !flush;
    assign ovf_set = winc && full  && !flush;
    assign udf_set = rinc && empty && !flush;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + ADDR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (udf_set) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (wdata),
        .re    (rd_ok),
        .raddr (rptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed, table-driven bench for sync_fifo_thresh (DATA_W=8, DEPTH=16, AF=14, AE=2).
module tb_sync_fifo_thresh;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
    logic [7:0] rdata;
    logic       flush;
    logic       err_clr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int passed = 0;
    int total  = 0;

    sync_fifo_thresh #(
        .DATA_W    (8),
        .DEPTH     (16),
        .AF_THRESH (14),
        .AE_THRESH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .winc         (winc),
        .wdata        (wdata),
        .rinc         (rinc),
        .rdata        (rdata),
        .flush        (flush),
        .err_clr      (err_clr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic [7:0] wd;
        logic       r;
        logic       fl;
        logic       ec;
        logic [4:0] cnt;
        logic [7:0] rd;
        logic       fu;
        logic       em;
        logic       af;
        logic       ae;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic w, input logic [7:0] wd, input logic r,
                                input logic fl, input logic ec, input logic [4:0] cnt,
                                input logic [7:0] rd, input logic fu, input logic em,
                                input logic af, input logic ae, input logic ov,
                                input logic un);
        vec_t v;
        v.w = w; v.wd = wd; v.r = r; v.fl = fl; v.ec = ec;
        v.cnt = cnt; v.rd = rd; v.fu = fu; v.em = em;
        v.af = af; v.ae = ae; v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] obs();
        return {count, rdata, full, empty, almost_full, almost_empty, overflow, underflow};
    endfunction

    // Apply one cycle of inputs, advance past the edge, then return to idle.
    task automatic cyc(input logic w, input logic [7:0] wd, input logic r,
                       input logic fl, input logic ec);
        winc = w; wdata = wd; rinc = r; flush = fl; err_clr = ec;
        @(posedge clk);
        #1;
        winc = 1'b0; rinc = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic chk_reset_state(input string name);
        chk(name, {13'd0, obs()}, {13'd0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    endtask

    logic [7:0] exp_q [$];
    logic [7:0] last_rd;

    initial begin
        rst_n = 1'b0; winc = 1'b0; wdata = 8'h00; rinc = 1'b0; flush = 1'b0; err_clr = 1'b0;

        //                 w   wd     r   fl  ec  cnt  rd     fu  em  af  ae  ov  un
        vecs[0]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 5'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 5'd1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[6]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[7]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 5'd1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 5'd2, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 5'd2, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 5'd0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset state, held across two edges.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset_state");
        rst_n = 1'b1;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].w, vecs[i].wd, vecs[i].r, vecs[i].fl, vecs[i].ec);
            chk($sformatf("vec%0d", i), {13'd0, obs()},
                {13'd0, vecs[i].cnt, vecs[i].rd, vecs[i].fu, vecs[i].em,
                 vecs[i].af, vecs[i].ae, vecs[i].ov, vecs[i].un});
        end

        // Fill 0x00..0x0F: threshold flags track the count.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            chk($sformatf("fill_cnt%0d", i), {27'd0, count}, 32'(i + 1));
            chk($sformatf("fill_flags%0d", i), {28'd0, full, almost_full, almost_empty, empty},
                {28'd0, 1'(i + 1 == 16), 1'(i + 1 >= 14), 1'(i + 1 <= 2), 1'b0});
        end

        // Write while full: rejected, overflow sets; then clear it.
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("full_wr_ovf", {30'd0, overflow, full}, {30'd0, 1'b1, 1'b1});
        chk("full_wr_cnt", {27'd0, count}, 32'd16);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", {31'd0, overflow}, 32'd0);

        // Write+read while full: read accepted, write rejected, overflow sets.
        cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("full_wr_rd", {19'd0, count, rdata}, {19'd0, 5'd15, 8'h00});
        chk("full_wr_rd_ovf", {31'd0, overflow}, 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Drain 0x01..0x0F in order; 0x55/0x77 must never appear.
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk($sformatf("drain_rd%0d", i), {24'd0, rdata}, 32'(i));
            chk($sformatf("drain_ae%0d", i), {30'd0, almost_empty, almost_full},
                {30'd0, 1'(15 - i <= 2), 1'(15 - i >= 14)});
        end
        chk("drain_empty", {26'd0, count, empty}, {26'd0, 5'd0, 1'b1});

        // Pointer wrap with overlapped traffic.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
            exp_q.push_back(8'hA0 + 8'(i));
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk($sformatf("wrap_rd%0d", i), {24'd0, rdata}, {24'd0, exp_q.pop_front()});
        end
        for (int j = 0; j < 12; j++) begin
            if (j < 4) begin
                cyc(1'b1, 8'hC0 + 8'(j), 1'b1, 1'b0, 1'b0);
                exp_q.push_back(8'hC0 + 8'(j));
                chk($sformatf("ovl_rd%0d", j), {24'd0, rdata}, {24'd0, exp_q.pop_front()});
                chk($sformatf("ovl_cnt%0d", j), {27'd0, count}, 32'd5);
            end else begin
                cyc(1'b1, 8'hC0 + 8'(j), 1'b0, 1'b0, 1'b0);
                exp_q.push_back(8'hC0 + 8'(j));
            end
        end
        chk("wrap_cnt", {27'd0, count}, 32'd13);
        for (int i = 0; i < 13; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk($sformatf("wrap_tail%0d", i), {24'd0, rdata}, {24'd0, exp_q.pop_front()});
        end
        chk("wrap_empty", {26'd0, count, empty}, {26'd0, 5'd0, 1'b1});
        last_rd = 8'hCB;

        // Flush with a concurrent write.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        chk("flush_state", {13'd0, obs()},
            {13'd0, 5'd0, last_rd, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});

        // Set underflow, start a burst, then reset asynchronously mid-burst.
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_udf", {31'd0, underflow}, 32'd1);
        cyc(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        winc = 1'b1; wdata = 8'h03;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        @(posedge clk);
        #1;
        chk_reset_state("reset_held");
        winc = 1'b0;
        rst_n = 1'b1;

        // Operation resumes after reset release.
        cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("resume", {19'd0, count, rdata}, {19'd0, 5'd0, 8'h5A});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
